// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory sequencer.
// DMEM_SWP_EN adds the swap states to the state enum.
package dmem_pkg;

  localparam int TIMEOUT_DEF = 15;
  localparam int CNT_W_DEF   = 4;

`ifdef DMEM_SWP_EN
  typedef enum logic [2:0] {IDLE, RD, WR, SWP_RD, SWP_WR, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RD, WR, DONE} state_t;
`endif

  function automatic logic [3:0] be_enc(input logic byte_acc, input logic [1:0] lane);
    be_enc = byte_acc ? (4'b0001 << lane) : 4'b1111;
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Per-phase wait counter; tc flags the cycle whose increment would reach TIMEOUT.
import dmem_pkg::*;

module dmem_timeout_cnt #(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + CNT_W'(1);
  end

  assign tc = en && (cnt == LAST);

endmodule

// File: rtl/dmem_seq_ctrl.sv
// MEM-stage sequencer for load/store/swap with per-phase timeout.
// Define DMEM_SWP_EN to build the read-then-write swap sequence.
import dmem_pkg::*;

module dmem_seq_ctrl #(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_ld,
  input  logic        req_st,
  input  logic        req_swp,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err
);

  state_t      state, state_nxt;
  logic        err_nxt;
  logic        phase_rd, phase_wr, in_phase;
  logic        tmo, accept;
  logic        byte_q;
  logic [1:0]  lane_q;
  logic        rd_nxt, wr_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_swp) begin
`ifdef DMEM_SWP_EN
            state_nxt = SWP_RD;
`else
            state_nxt = DONE;
            err_nxt   = 1'b1;
`endif
          end else if (req_st) begin
            state_nxt = WR;
          end else if (req_ld) begin
            state_nxt = RD;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      RD, WR: begin
        if (mem_ack) begin
          state_nxt = DONE;
        end else if (tmo) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
`ifdef DMEM_SWP_EN
      SWP_RD: begin
        if (mem_ack) begin
          state_nxt = SWP_WR;
        end else if (tmo) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
      SWP_WR: begin
        if (mem_ack) begin
          state_nxt = DONE;
        end else if (tmo) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      end
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    phase_rd = 1'b0;
    phase_wr = 1'b0;
    stall    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: stall = req_valid;
      RD: begin
        phase_rd = 1'b1;
        stall    = 1'b1;
      end
      WR: begin
        phase_wr = 1'b1;
        stall    = 1'b1;
      end
`ifdef DMEM_SWP_EN
      SWP_RD: begin
        phase_rd = 1'b1;
        stall    = 1'b1;
      end
      SWP_WR: begin
        phase_wr = 1'b1;
        stall    = 1'b1;
      end
`endif
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  assign in_phase = phase_rd || phase_wr;
  assign accept   = (state == IDLE) && req_valid;

  // Counter restarts whenever no phase is active or a phase completes.
  dmem_timeout_cnt #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (!in_phase || mem_ack),
    .en  (in_phase && !mem_ack),
    .tc  (tmo)
  );

`ifdef DMEM_SWP_EN
  assign rd_nxt = (state_nxt == RD) || (state_nxt == SWP_RD);
  assign wr_nxt = (state_nxt == WR) || (state_nxt == SWP_WR);
`else
  assign rd_nxt = (state_nxt == RD);
  assign wr_nxt = (state_nxt == WR);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      err       <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata     <= '0;
      byte_q    <= 1'b0;
      lane_q    <= '0;
    end else begin
      mem_rd <= rd_nxt;
      mem_wr <= wr_nxt;
      err    <= err_nxt;
      if (accept) begin
        byte_q    <= req_byte;
        lane_q    <= req_addr[1:0];
        mem_addr  <= {req_addr[31:2], 2'b00};
        mem_wdata <= req_byte ? {4{req_wdata[7:0]}} : req_wdata;
        mem_be    <= be_enc(req_byte, req_addr[1:0]);
      end
      if (phase_rd && mem_ack)
        rdata <= byte_q ? {24'd0, mem_rdata[8*lane_q +: 8]} : mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_seq_ctrl.sv
// Directed bench for dmem_seq_ctrl with a simple word-addressed memory responder.
// Swap checks follow DMEM_SWP_EN.
module tb_dmem_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ld = 1'b0, req_st = 1'b0, req_swp = 1'b0, req_byte = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        mem_rd, mem_wr, stall, done, err;
  logic [31:0] mem_addr, mem_wdata, rdata;
  logic [3:0]  mem_be;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [256];
  int          n_rd, n_wr, n_done, n_err, lat;
  logic        stall_done, err_done;
  logic [3:0]  be_wr, be_rd;
  logic [31:0] addr_wr, wdata_wr, rdata_prev;
  int          strobes;

  dmem_seq_ctrl #(.TIMEOUT(15), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ld    (req_ld),
    .req_st    (req_st),
    .req_swp   (req_swp),
    .req_byte  (req_byte),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .stall     (stall),
    .rdata     (rdata),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request and plays memory: ack after w_rd / w_wr wait cycles per phase.
  task automatic run_req(input logic ld, input logic st, input logic swp, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int w_rd, input int w_wr, input int max_cyc);
    int   wc;
    logic pstb, pack, pwr, fin;
    wc = 0; pstb = 0; pack = 0; pwr = 0; fin = 0;
    n_rd = 0; n_wr = 0; n_done = 0; n_err = 0; lat = -1;
    stall_done = 1'bx; err_done = 1'bx;
    be_wr = '0; be_rd = '0; addr_wr = '0; wdata_wr = '0;
    for (int cyc = 0; cyc < max_cyc && !fin; cyc++) begin
      @(negedge clk);
      if (pstb) begin
        if (pack) begin
          if (pwr)
            for (int i = 0; i < 4; i++)
              if (mem_be[i]) mem[mem_addr[9:2]][8*i +: 8] = mem_wdata[8*i +: 8];
          wc = 0;
        end else begin
          wc++;
        end
      end
      if (cyc == 0) begin
        req_valid = 1'b1; req_ld = ld; req_st = st; req_swp = swp; req_byte = byt;
        req_addr = addr; req_wdata = wdata;
      end
      #1;
      pstb = mem_rd | mem_wr;
      pwr  = mem_wr;
      mem_ack = pstb && (wc >= (mem_wr ? w_wr : w_rd));
      pack = mem_ack;
      mem_rdata = mem[mem_addr[9:2]];
      if (mem_rd) begin n_rd++; be_rd = mem_be; end
      if (mem_wr) begin n_wr++; be_wr = mem_be; addr_wr = mem_addr; wdata_wr = mem_wdata; end
      if (err) n_err++;
      if (done) begin
        n_done++; lat = cyc; stall_done = stall; err_done = err; fin = 1;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_ld = 1'b0; req_st = 1'b0; req_swp = 1'b0; req_byte = 1'b0;
    mem_ack = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_done_err_stall", {29'd0, done, err, stall}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata_be", mem_wdata | {28'd0, mem_be}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ack while idle is ignored
    @(negedge clk);
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("idle_ack", {28'd0, mem_rd, mem_wr, done, stall}, 32'd0);
    mem_ack = 1'b0;

    // word load, two wait states
    mem[32'h104 >> 2] = 32'hDEADBEEF;
    run_req(1, 0, 0, 0, 32'h104, 32'h0, 2, 0, 40);
    chk("ld_rd_cycles", n_rd, 3);
    chk("ld_rdata", rdata, 32'hDEADBEEF);
    chk("ld_done_cnt", n_done, 1);
    chk("ld_latency", lat, 4);
    chk("ld_stall_in_done", {31'd0, stall_done}, 32'd0);
    chk("ld_be", {28'd0, be_rd}, 32'hF);

    // byte store to lane 3
    run_req(0, 1, 0, 1, 32'h203, 32'h000000A5, 0, 0, 40);
    chk("stb_be", {28'd0, be_wr}, 32'h8);
    chk("stb_wdata", wdata_wr, 32'hA5A5A5A5);
    chk("stb_addr", addr_wr, 32'h200);
    chk("stb_latency", lat, 2);
    chk("stb_mem", mem[32'h200 >> 2], 32'hA5000000);

    // byte load of the same lane, zero-extended
    run_req(1, 0, 0, 1, 32'h203, 32'h0, 0, 0, 40);
    chk("ldb_rdata", rdata, 32'h000000A5);
    chk("ldb_be", {28'd0, be_rd}, 32'h8);

    // store wins over load; word store then unaligned word load
    run_req(1, 1, 0, 0, 32'h10, 32'h12345678, 0, 0, 40);
    chk("pri_rd_cnt", n_rd, 0);
    chk("pri_wr_cnt", n_wr, 1);
    chk("st_mem", mem[4], 32'h12345678);
    run_req(1, 0, 0, 0, 32'h12, 32'h0, 1, 0, 40);
    chk("ldw_rdata", rdata, 32'h12345678);
    chk("ldw_latency", lat, 3);

    // request with no operation
    run_req(0, 0, 0, 0, 32'h44, 32'h0, 0, 0, 40);
    chk("nop_latency", lat, 1);
    chk("nop_strobes", n_rd + n_wr, 0);
    chk("nop_err", {31'd0, err_done}, 32'd0);

`ifdef DMEM_SWP_EN
    mem[32'h300 >> 2] = 32'h11111111;
    run_req(0, 0, 1, 0, 32'h300, 32'h22222222, 0, 0, 40);
    chk("swp_rd_cnt", n_rd, 1);
    chk("swp_wr_cnt", n_wr, 1);
    chk("swp_latency", lat, 3);
    chk("swp_rdata", rdata, 32'h11111111);
    chk("swp_mem", mem[32'h300 >> 2], 32'h22222222);
    chk("swp_wr_addr", addr_wr, 32'h300);
    chk("swp_err", n_err, 0);

    // read-phase timeout must not start the write phase
    rdata_prev = rdata;
    run_req(0, 0, 1, 0, 32'h300, 32'h33333333, 100, 0, 40);
    chk("swp_tmo_wr_cnt", n_wr, 0);
    chk("swp_tmo_err", {31'd0, err_done}, 32'd1);
    chk("swp_tmo_rdata", rdata, rdata_prev);
    chk("swp_tmo_mem", mem[32'h300 >> 2], 32'h22222222);
`else
    run_req(0, 0, 1, 0, 32'h300, 32'h22222222, 0, 0, 40);
    chk("swp_off_strobes", n_rd + n_wr, 0);
    chk("swp_off_err", {31'd0, err_done}, 32'd1);
    chk("swp_off_err_cnt", n_err, 1);
    chk("swp_off_latency", lat, 1);
`endif

    // load timeout after 15 unanswered cycles, then a normal load
    rdata_prev = rdata;
    run_req(1, 0, 0, 0, 32'h40, 32'h0, 100, 0, 40);
    chk("tmo_rd_cycles", n_rd, 15);
    chk("tmo_latency", lat, 16);
    chk("tmo_err", {31'd0, err_done}, 32'd1);
    chk("tmo_err_cnt", n_err, 1);
    chk("tmo_rdata", rdata, rdata_prev);
    run_req(1, 0, 0, 0, 32'h104, 32'h0, 0, 0, 40);
    chk("post_tmo_rdata", rdata, 32'hDEADBEEF);
    chk("post_tmo_latency", lat, 2);
    chk("post_tmo_err", n_err, 0);

    // asynchronous reset in the middle of a waiting phase
`ifdef DMEM_SWP_EN
    run_req(0, 0, 1, 0, 32'h300, 32'h44444444, 0, 100, 4);
    @(negedge clk);
    chk("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
`else
    run_req(1, 0, 0, 0, 32'h104, 32'h0, 100, 0, 4);
    @(negedge clk);
    chk("pre_rst_rd", {31'd0, mem_rd}, 32'd1);
`endif
    rst = 1'b1;
    #1;
    chk("arst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("arst_stall_done_err", {29'd0, stall, done, err}, 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_wdata_be", mem_wdata | {28'd0, mem_be}, 32'd0);
    chk("arst_rdata", rdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (mem_rd || mem_wr) strobes++;
    end
    chk("post_rst_strobes", strobes, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
